seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Receiving end of the multiplexed four-digit seven-segment interface: samples the active-low anode/segment bus, qualifies each digit strobe, and rebuilds the full four-digit frame.
- Used as a loopback/self-check monitor in the SoC: display drivers feed it, and it gives firmware and benches a stable readback of what is shown.
- Segment bit order is {dp,g,f,e,d,c,b,a}. Digit 0 is an[0] (rightmost).

Parameters:
- SETTLE_CYCLES, 16: consecutive cycles an/seg must hold one value before a digit is captured (min 2).
- TIMEOUT_CYCLES, 200_000: cycles without any capture before the frame is declared stale.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- an  input  4  anode strobes, active-low, one-hot-low expected
- seg  input  8  segments, active-low, {dp,g,f,e,d,c,b,a}
- frame  output  32  last complete frame, active-high; frame[8i+7:8i] = digit i
- frame_valid  output  1  one-cycle pulse when frame updates
- frame_changed  output  1  one-cycle pulse with frame_valid if the new frame differs from the previous one
- an_error  output  1  registered-anode pattern has more than one zero
- stale  output  1  no capture for TIMEOUT_CYCLES
- hex  output  16  decoded hex nibble per digit (optional feature)
- hex_ok  output  4  per-digit decode-recognised flag (optional feature)

Behaviour:
- Reset: single clock domain. Sync active-low reset, sampled on posedge clk; state is not affected asynchronously. Reset clears all of the following to 0: frame, frame_valid, frame_changed, an_error, stale, hex, hex_ok, shadow registers, seen[3:0], stability counter, timeout counter and captured flag.
- Input stage: an/seg pass through one register stage (an_q, seg_q). All decisions below use the registered values.
- Anode classification:
  - idle: an_q = 4'b1111.
  - valid: exactly one zero; index = position of that zero.
  - error: two or more zeros. an_error = 1 on each such cycle, combinationally from an_q. The stability counter is cleared and no capture occurs.
- Stability counter:
  - Increments while {an_q,seg_q} equals its previous-cycle value and is valid; saturates.
  - Any change, idle or error clears it to 0 and clears the captured flag.
- Capture: occurs on the edge at which one valid {an_q,seg_q} value has been present for SETTLE_CYCLES consecutive cycles.
  - Captured flag set: shadow[idx] <= ~seg_q, seen[idx] <= 1.
  - Only one capture per strobe. The captured flag blocks repeats until the strobe changes.
- Repeat digit: a repeated capture of an already-seen digit within a frame overwrites shadow[idx]. seen is unchanged.
- Frame completion:
  - Condition: the cycle after seen == 4'b1111.
  - On that edge: frame <= shadow, frame_valid = 1 for one cycle, frame_changed = 1 if shadow != old frame, seen <= 0.
  - Latency: one cycle after the 4th capture.
  - A capture on that same cycle is kept: its seen bit survives the clear.
- Timeout:
  - Counter is cleared on every capture and saturates at TIMEOUT_CYCLES-1; stale is set on that cycle.
  - On reaching it: stale <= 1 and seen <= 0. frame is retained.
  - stale clears on the next frame_valid.
- Reset mid-frame discards partial seen/shadow. The first post-reset frame needs all four digits again.

Optional Feature:
- Macro: SEG7_SCAN_HEX_DECODE_EN.
- Defined: hex/hex_ok update registered together with frame. For each digit, decode frame bits [6:0] (dp ignored):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Unmatched pattern: nibble 0, hex_ok bit 0.
- Undefined: decode logic is absent; hex = 0 and hex_ok = 0 always. Ports remain present.

Test Plan:
Bench uses SETTLE_CYCLES=4 and TIMEOUT_CYCLES=64.
1. Reset: rst_n=0 for 2 cycles with an=0000 driven -> frame=0, frame_valid=0, frame_changed=0, stale=0, hex_ok=0. The an_error output follows an_q.
2. Full scan: (1110,C0), (1101,F9), (1011,A4), (0111,B0), each held 8 cycles -> exactly one frame_valid, frame=32'h4F5B063F, frame_changed=1. With macro: hex=16'h3210, hex_ok=4'hF. Repeating the identical scan -> frame_valid=1, frame_changed=0.
3. Glitch rejection: each strobe held 3 cycles -> no capture, no frame_valid, frame unchanged. Then one strobe held 20 cycles -> exactly one capture for it.
4. Anode error: an=1100, seg=00 for 10 cycles -> an_error=1 on those registered cycles, seen unchanged, no frame_valid.
5. Timeout: after scenario 2, an=1111 for 70 cycles -> stale=1 from the 64th cycle after the last capture, frame still 4F5B063F. A new full scan -> frame_valid, stale=0.
6. Reset mid-frame: capture digits 0 and 1, rst_n=0 for 1 cycle, then capture digits 2 and 3 -> no frame_valid, frame=0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Multiplexed seven-segment bus (an/seg) plus the rebuilt-frame readback of the capture monitor.
interface seg7_scan_if;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [31:0] frame;
   logic        frame_valid;
   logic        frame_changed;
   logic        an_error;
   logic        stale;
   logic [15:0] hex;
   logic [3:0]  hex_ok;

   modport master (output an, seg,
                   input  frame, frame_valid, frame_changed, an_error, stale, hex, hex_ok);
   modport slave  (input  an, seg,
                   output frame, frame_valid, frame_changed, an_error, stale, hex, hex_ok);
endinterface

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 4-digit active-low seven-segment bus and rebuilds the displayed frame.
// Optional hex readback of the frame is enabled with `define SEG7_SCAN_HEX_DECODE_EN.
module seg7_scan_capture #(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
   input  logic       clk,
   input  logic       rst_n,
   seg7_scan_if.slave bus
);
   localparam int unsigned CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES - 1) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   // Counter value seen on the edge where the value has been stable SETTLE_CYCLES cycles
   localparam logic [CW-1:0] CNT_CAP  = CW'(SETTLE_CYCLES - 2);
   localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TOUT_PRE = TW'(TIMEOUT_CYCLES - 2);

   logic [3:0]       an_q;
   logic [7:0]       seg_q;
   logic [11:0]      prev_q;
   logic [CW-1:0]    cnt;
   logic             captured;
   logic [TW-1:0]    tcnt;
   logic [3:0][7:0]  shadow;
   logic [3:0]       seen;
   logic [31:0]      frame_r;
   logic             fv_r;
   logic             fc_r;
   logic             stale_r;

   logic             an_valid;
   logic             an_err;
   logic [1:0]       idx;
   logic             same;
   logic             cap;
   logic             done;
   logic             timeout;

   // Anode classification and capture/completion/timeout decisions from the registered bus
   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!an_q[i]) idx = 2'(i);
      end
      an_valid = ($countones(~an_q) == 1);
      an_err   = ($countones(~an_q) > 1);
      same     = ({an_q, seg_q} == prev_q);
      cap      = an_valid && same && !captured && (cnt == CNT_CAP);
      done     = (seen == 4'hF);
      timeout  = !cap && (tcnt >= TOUT_PRE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_q     <= 4'hF;
         seg_q    <= 8'hFF;
         prev_q   <= '0;
         cnt      <= '0;
         captured <= 1'b0;
         tcnt     <= '0;
         shadow   <= '0;
         seen     <= '0;
         frame_r  <= '0;
         fv_r     <= 1'b0;
         fc_r     <= 1'b0;
         stale_r  <= 1'b0;
      end else begin
         an_q   <= bus.an;
         seg_q  <= bus.seg;
         prev_q <= {an_q, seg_q};

         if (an_valid && same) begin
            if (cnt != CNT_CAP) cnt <= cnt + CW'(1);
         end else begin
            cnt      <= '0;
            captured <= 1'b0;
         end

         if (cap) tcnt <= '0;
         else if (tcnt != TOUT_MAX) tcnt <= tcnt + TW'(1);

         fv_r <= done;
         fc_r <= done && (shadow != frame_r);
         if (done) begin
            frame_r <= shadow;
            stale_r <= 1'b0;
         end else if (timeout) begin
            stale_r <= 1'b1;
         end

         // A capture on the completion edge keeps its seen bit (last assignment wins)
         if (done || timeout) seen <= '0;
         if (cap) begin
            captured    <= 1'b1;
            shadow[idx] <= ~seg_q;
            seen[idx]   <= 1'b1;
         end
      end
   end

   assign bus.frame         = frame_r;
   assign bus.frame_valid   = fv_r;
   assign bus.frame_changed = fc_r;
   assign bus.an_error      = an_err;
   assign bus.stale         = stale_r;

`ifdef SEG7_SCAN_HEX_DECODE_EN
   logic [15:0] hex_r;
   logic [3:0]  hex_ok_r;

   // Returns {recognised, nibble}; dp is excluded by the caller
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h3F: return {1'b1, 4'h0};
         7'h06: return {1'b1, 4'h1};
         7'h5B: return {1'b1, 4'h2};
         7'h4F: return {1'b1, 4'h3};
         7'h66: return {1'b1, 4'h4};
         7'h6D: return {1'b1, 4'h5};
         7'h7D: return {1'b1, 4'h6};
         7'h07: return {1'b1, 4'h7};
         7'h7F: return {1'b1, 4'h8};
         7'h6F: return {1'b1, 4'h9};
         7'h77: return {1'b1, 4'hA};
         7'h7C: return {1'b1, 4'hB};
         7'h39: return {1'b1, 4'hC};
         7'h5E: return {1'b1, 4'hD};
         7'h79: return {1'b1, 4'hE};
         7'h71: return {1'b1, 4'hF};
         default: return 5'd0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hex_r    <= '0;
         hex_ok_r <= '0;
      end else if (done) begin
         for (int i = 0; i < 4; i++) begin
            {hex_ok_r[i], hex_r[4*i +: 4]} <= decode(shadow[i][6:0]);
         end
      end
   end

   assign bus.hex    = hex_r;
   assign bus.hex_ok = hex_ok_r;
`else
   assign bus.hex    = '0;
   assign bus.hex_ok = '0;
`endif
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomised bench for seg7_scan_capture against a run-length based reference model.
module tb_seg7_scan_capture;
   localparam int unsigned S = 4;
   localparam int unsigned T = 64;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   fv_count = 0;
   logic last_fc = 1'b0;

   seg7_scan_if bus_if();

   seg7_scan_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   function automatic int zeros(input logic [3:0] a);
      int n = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) n++;
      return n;
   endfunction

   // Reference model: a digit is taken when the registered value has run for S cycles
   logic [3:0]  m_aq;
   logic [7:0]  m_sq;
   logic [11:0] m_prev;
   int          m_run;
   int          m_since;
   logic [7:0]  m_shadow [4];
   logic [3:0]  m_seen;
   logic [31:0] m_frame;
   logic        m_fv, m_fc, m_stale;
   logic [15:0] m_hex;
   logic [3:0]  m_hex_ok;
   bit          m_live = 1'b0;

   always @(posedge clk) begin
      int          idx;
      bit          cap, done;
      logic [31:0] packed_sh;
      if (!rst_n) begin
         m_aq = 4'hF; m_sq = 8'hFF; m_prev = '0; m_run = 0; m_since = 0;
         for (int i = 0; i < 4; i++) m_shadow[i] = '0;
         m_seen = '0; m_frame = '0; m_fv = 0; m_fc = 0; m_stale = 0;
         m_hex = '0; m_hex_ok = '0; m_live = 1'b1;
      end else begin
         m_run  = ({m_aq, m_sq} == m_prev) ? m_run + 1 : 1;
         m_prev = {m_aq, m_sq};
         idx = 0;
         for (int i = 0; i < 4; i++) if (!m_aq[i]) idx = i;
         cap  = (zeros(m_aq) == 1) && (m_run == S);
         done = (m_seen == 4'hF);
         packed_sh = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
         m_fv = done;
         m_fc = done && (packed_sh != m_frame);
         if (done) begin
            m_frame = packed_sh;
            m_seen  = '0;
            m_stale = 1'b0;
`ifdef SEG7_SCAN_HEX_DECODE_EN
            for (int d = 0; d < 4; d++) begin
               m_hex[4*d +: 4] = 4'h0;
               m_hex_ok[d] = 1'b0;
               for (int k = 0; k < 16; k++) begin
                  if (seg_tab[k][6:0] == m_shadow[d][6:0]) begin
                     m_hex[4*d +: 4] = 4'(k);
                     m_hex_ok[d] = 1'b1;
                  end
               end
            end
`endif
         end
         m_since = cap ? 0 : m_since + 1;
         if (!cap && m_since >= T - 1) begin
            m_seen = '0;
            if (!done) m_stale = 1'b1;
         end
         if (cap) begin
            m_shadow[idx] = ~m_sq;
            m_seen[idx]   = 1'b1;
         end
      end
      m_aq = rst_n ? bus_if.an  : 4'hF;
      m_sq = rst_n ? bus_if.seg : 8'hFF;
   end

   // Cycle-by-cycle comparison, sampled on the falling edge
   always @(negedge clk) begin
      if (m_live) begin
         check("frame", bus_if.frame, m_frame);
         check("frame_valid", 32'(bus_if.frame_valid), 32'(m_fv));
         check("frame_changed", 32'(bus_if.frame_changed), 32'(m_fc));
         check("an_error", 32'(bus_if.an_error), 32'(zeros(m_aq) > 1));
         check("stale", 32'(bus_if.stale), 32'(m_stale));
         check("hex", 32'(bus_if.hex), 32'(m_hex));
         check("hex_ok", 32'(bus_if.hex_ok), 32'(m_hex_ok));
         if (bus_if.frame_valid === 1'b1) begin
            fv_count++;
            last_fc = bus_if.frame_changed;
         end
      end
   end

   task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
      bus_if.an  = a;
      bus_if.seg = s;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [3:0] strobe(input int d);
      logic [3:0] one = 4'b0001;
      return ~(one << d);
   endfunction

   task automatic digit(input int d, input logic [7:0] s, input int n);
      hold(strobe(d), s, n);
   endtask

   task automatic scan(input logic [31:0] segs, input int n);
      for (int d = 0; d < 4; d++) digit(d, segs[8*d +: 8], n);
      hold(4'hF, 8'hFF, 4);
   endtask

   function automatic logic [7:0] rand_seg();
      logic [7:0] pat = seg_tab[$urandom_range(0, 15)];
      return ($urandom_range(0, 1) == 1) ? ~pat : 8'($urandom);
   endfunction

   initial begin
      int          base;
      logic [31:0] segs;
      logic [7:0]  g;

      // Reset with all anodes low on the bus
      rst_n = 1'b0;
      bus_if.an  = 4'b0000;
      bus_if.seg = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_frame", bus_if.frame, 32'h0);
      check("rst_fv", 32'(bus_if.frame_valid), 32'h0);
      check("rst_fc", 32'(bus_if.frame_changed), 32'h0);
      check("rst_stale", 32'(bus_if.stale), 32'h0);
      check("rst_hex_ok", 32'(bus_if.hex_ok), 32'h0);
      check("rst_an_error", 32'(bus_if.an_error), 32'h0);
      bus_if.an  = 4'hF;
      bus_if.seg = 8'hFF;
      rst_n = 1'b1;
      hold(4'hF, 8'hFF, 2);

      // Full scan, then identical repeat
      base = fv_count;
      scan(32'hB0A4F9C0, 8);
      check("scan1_fv_count", 32'(fv_count - base), 32'd1);
      check("scan1_frame", bus_if.frame, 32'h4F5B063F);
      check("scan1_changed", 32'(last_fc), 32'd1);
`ifdef SEG7_SCAN_HEX_DECODE_EN
      check("scan1_hex", 32'(bus_if.hex), 32'h3210);
      check("scan1_hex_ok", 32'(bus_if.hex_ok), 32'hF);
`endif
      base = fv_count;
      scan(32'hB0A4F9C0, 8);
      check("scan2_fv_count", 32'(fv_count - base), 32'd1);
      check("scan2_changed", 32'(last_fc), 32'd0);

      // Glitch rejection, then one long strobe completes a frame with three others
      base = fv_count;
      for (int d = 0; d < 4; d++) digit(d, rand_seg(), 3);
      hold(4'hF, 8'hFF, 4);
      check("glitch_fv_count", 32'(fv_count - base), 32'd0);
      check("glitch_frame", bus_if.frame, 32'h4F5B063F);
      g = rand_seg();
      segs = {rand_seg(), rand_seg(), rand_seg(), g};
      digit(0, g, 20);
      for (int d = 1; d < 4; d++) digit(d, segs[8*d +: 8], 8);
      hold(4'hF, 8'hFF, 4);
      check("long_fv_count", 32'(fv_count - base), 32'd1);
      check("long_frame", bus_if.frame, ~segs);

      // Anode error between digits leaves seen intact
      base = fv_count;
      segs = {rand_seg(), rand_seg(), rand_seg(), rand_seg()};
      digit(0, segs[7:0], 8);
      hold(4'b1100, 8'h00, 5);
      check("err_an_error", 32'(bus_if.an_error), 32'd1);
      hold(4'b1100, 8'h00, 5);
      check("err_fv_count", 32'(fv_count - base), 32'd0);
      for (int d = 1; d < 4; d++) digit(d, segs[8*d +: 8], 8);
      hold(4'hF, 8'hFF, 4);
      check("err_resume_fv", 32'(fv_count - base), 32'd1);
      check("err_resume_frame", bus_if.frame, ~segs);

      // Timeout after a known frame, then recovery
      scan(32'hB0A4F9C0, 8);
      hold(4'hF, 8'hFF, 66);
      check("tout_stale", 32'(bus_if.stale), 32'd1);
      check("tout_frame", bus_if.frame, 32'h4F5B063F);
      base = fv_count;
      segs = {rand_seg(), rand_seg(), rand_seg(), rand_seg()};
      scan(segs, 6);
      check("tout_fv_count", 32'(fv_count - base), 32'd1);
      check("tout_stale_clr", 32'(bus_if.stale), 32'd0);

      // Reset mid-frame discards partial digits
      base = fv_count;
      digit(0, 8'hC0, 8);
      digit(1, 8'hF9, 8);
      hold(4'hF, 8'hFF, 1);
      rst_n = 1'b0;
      hold(4'hF, 8'hFF, 1);
      rst_n = 1'b1;
      digit(2, 8'hA4, 8);
      digit(3, 8'hB0, 8);
      hold(4'hF, 8'hFF, 8);
      check("mid_rst_fv", 32'(fv_count - base), 32'd0);
      check("mid_rst_frame", bus_if.frame, 32'h0);

      // Random strobes, hold lengths, idle and error patterns
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 9))
            0:       hold(4'hF, 8'hFF, $urandom_range(1, 6));
            1:       hold(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(1, 4));
            default: digit($urandom_range(0, 3), rand_seg(), $urandom_range(1, 9));
         endcase
      end
      for (int it = 0; it < 6; it++) scan({rand_seg(), rand_seg(), rand_seg(), rand_seg()}, $urandom_range(4, 9));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
